// File: rtl/npu_bram_pkg.sv
// Shared types and constants for the NPU BRAM buffer and its stream reader.
package npu_bram_pkg;

  localparam int BIT_DEPTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DEPTH_DEF      = 784;

  localparam int RD_LATENCY = 1;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_e;

endpackage

// File: rtl/bram_reader_skid.sv
// Two-entry FIFO holding {last, data} beats between the BRAM read port and the stream output.
module bram_reader_skid
  import npu_bram_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps a BRAM address range and presents the words as a valid/ready stream.
// Optional stall counter output enabled by defining BRAM_READER_STALL_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing BRAM reads, throttled by skid occupancy
// DRAIN  | all reads issued, waiting for in-flight data and skid to empty
// FINISH | one-cycle done pulse, busy low
module bram_stream_reader
  import npu_bram_pkg::*;
#(
  parameter int BIT_DEPTH  = BIT_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BIT_DEPTH-1:0]  rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BIT_DEPTH-1:0]  m_data,
  output logic                  m_last
`ifdef BRAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

  rd_state_e             state, state_nxt;
  logic [ADDR_WIDTH:0]   len_sat;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   push_left;
  logic                  inflight;
  logic                  start_ok;
  logic                  pop;
  logic                  room;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [BIT_DEPTH:0]    fifo_head;

  assign len_sat  = (length > DEPTH_L) ? DEPTH_L : length;
  assign start_ok = (state == IDLE) && start;
  assign pop      = m_valid && m_ready;
  // Fewer than two words held or in flight: count 0, or count 1 with nothing in flight.
  assign room     = fifo_empty || (!fifo_full && !inflight);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? FINISH : READ;
      end
      READ: begin
        rd_en = room || pop;
        if (rd_en && issue_left == ONE_L) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == 2'd0 && !inflight) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr    <= '0;
      issue_left <= '0;
      push_left  <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (start_ok) begin
        rd_addr    <= base_addr;
        issue_left <= len_sat;
        push_left  <= len_sat;
      end else begin
        if (rd_en) begin
          rd_addr    <= (rd_addr == LAST_A) ? '0 : rd_addr + 1'b1;
          issue_left <= issue_left - ONE_L;
        end
        if (inflight) push_left <= push_left - ONE_L;
      end
    end
  end

  bram_reader_skid #(
    .W (BIT_DEPTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({(push_left == ONE_L), rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_head[BIT_DEPTH-1:0];
  assign m_last  = fifo_head[BIT_DEPTH];
  assign busy    = (state == READ) || (state == DRAIN);
  assign done    = (state == FINISH);

`ifdef BRAM_READER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               stall_cnt <= '0;
    else if (start_ok)                                     stall_cnt <= '0;
    else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized self-checking bench for bram_stream_reader against a queue-based sweep model.
`timescale 1ns/1ps
module tb_bram_stream_reader;
  import npu_bram_pkg::*;

  localparam int BD = 8;
  localparam int AW = 10;
  localparam int DP = 784;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [BD-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [BD-1:0] m_data;
  logic          m_last;
`ifdef BRAM_READER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [BD-1:0] mem [DP];

  bram_stream_reader #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef BRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle registered read.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_sweep(input int base, input int len, input int mode,
                           input bit repulse, input int abort_at);
    int n, k, beats, rd_cnt, first_k, last_k, stalls, budget;
    bit fin, aborted, prev_stall, ovf;
    logic [BD-1:0] prev_d;
    logic prev_l;
    logic [BD-1:0] exp_q[$];
    int addr_q[$];

    n = (len > DP) ? DP : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[(base + i) % DP]);
      addr_q.push_back((base + i) % DP);
    end
    k = 1; beats = 0; rd_cnt = 0; first_k = -1; last_k = -1; stalls = 0;
    fin = 0; aborted = 0; prev_stall = 0; ovf = 0; prev_d = '0; prev_l = 0;
    budget = 4 * n + 40;

    @(negedge clk);
    base_addr = AW'(base); length = (AW + 1)'(len); start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = AW'($urandom); length = (AW + 1)'($urandom);

    while (!fin && k < budget) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 3 == 0);
        default: m_ready = ($urandom % 4) != 0;
      endcase
      if (repulse && k == 5) begin
        start = 1'b1; base_addr = AW'((base + 100) % DP); length = 11'd7;
      end else start = 1'b0;
      #1;
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_d);
        chk("hold_last", m_last, prev_l);
      end
      if (m_valid && first_k < 0) first_k = k;
      if (rd_en) begin
        rd_cnt++;
        if (rd_cnt <= n) chk("rd_addr", rd_addr, addr_q[rd_cnt-1]);
      end
      ovf |= dut.inflight && dut.fifo_full && !(m_valid && m_ready);
      if (m_valid && m_ready) begin
        beats++;
        last_k = k;
        if (beats <= n) begin
          chk("beat_data", m_data, exp_q[beats-1]);
          chk("beat_last", m_last, beats == n);
        end
      end
      if (m_valid && !m_ready) stalls++;
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      if (done) begin
        chk("busy_in_done", busy, 0);
        chk("done_beats", beats, n);
        if (n == 0) chk("done_latency", k, 1);
        fin = 1;
      end
      if (abort_at > 0 && beats == abort_at) begin
        aborted = 1;
        fin = 1;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    chk("sweep_finished", fin, 1);

    if (aborted) begin
      rst = 1'b1;
      #1;
      chk("rst_outputs", {busy, done, rd_en, rd_addr, m_valid, m_data, m_last}, 0);
`ifdef BRAM_READER_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
    end else begin
      #1;
      chk("rd_count", rd_cnt, n);
      chk("beat_count", beats, n);
      chk("skid_overflow", ovf, 0);
      if (n > 0) chk("first_beat_latency", first_k, 3);
      else       chk("no_valid", first_k, -1);
      if (mode == 0 && n > 0) chk("gapless", last_k - first_k, n - 1);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", m_valid, 0);
`ifdef BRAM_READER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stalls);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    for (int i = 0; i < DP; i++) mem[i] = BD'(i + 1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {busy, done, rd_en, rd_addr, m_valid, m_data, m_last}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 4, 0, 0, 0);
    run_sweep(10, 8, 1, 0, 0);
    run_sweep(782, 4, 0, 0, 0);
    run_sweep(0, 0, 0, 0, 0);
    run_sweep(0, 20, 0, 0, 3);
    run_sweep(0, 2, 0, 0, 0);
    run_sweep(5, 1000, 0, 1, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DP; i++) mem[i] = BD'($urandom);
      run_sweep($urandom_range(0, DP - 1), $urandom_range(1, 40), 2, 0, 0);
    end
    run_sweep($urandom_range(0, DP - 1), $urandom_range(1, 60), 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
